// File: rtl/divisor_scheduler.sv
// Round-robin time-sharing of one external frequency divider among NREQ requesters.
// Optional define DIVSCHED_ABORT_EN: dropping req of the owner mid-job aborts it without a done pulse.
module divisor_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_div,
    input  logic [NREQ*CW-1:0]   req_cycles,
    input  logic                 divf_in,
    output logic [31:0]          div_in,
    output logic                 div_rst_n,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [NREQ-1:0]      done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: req is a level held by the requester until its done pulse;
    // done is a single-cycle pulse coincident with the last cycle of grant.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [31:0]     div_lat_q, div_lat_d;
    logic [CW-1:0]   cyc_lat_q, cyc_lat_d;
    logic [CW-1:0]   edge_cnt_q, edge_cnt_d;
    logic            divf_q, divf_d;
    logic [31:0]     div_in_q, div_in_d;
    logic            rst_n_q, rst_n_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;

    logic [IW-1:0]   win;
    logic [IW-1:0]   probe;
    logic            found;
    logic [31:0]     div_sel;
    logic [CW-1:0]   cyc_sel;
    logic            rise;
    logic            abort;

    // Search starts one past the previous winner so every requester is reached within NREQ jobs.
    always_comb begin
        win   = '0;
        probe = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            probe = (int'(last_q) + i >= NREQ) ? IW'(int'(last_q) + i - NREQ) : IW'(int'(last_q) + i);
            if (!found && req[probe]) begin
                win   = probe;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        div_sel = '0;
        cyc_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                div_sel = req_div[32*i +: 32];
                cyc_sel = req_cycles[CW*i +: CW];
            end
        end
    end

    assign rise = divf_in & ~divf_q;

`ifdef DIVSCHED_ABORT_EN
    assign abort = ~req[idx_q];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        div_lat_d  = div_lat_q;
        cyc_lat_d  = cyc_lat_q;
        edge_cnt_d = edge_cnt_q;
        divf_d     = divf_in;
        div_in_d   = div_in_q;
        rst_n_d    = rst_n_q;
        grant_d    = grant_q;
        done_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d     = win;
                    last_d    = win;
                    div_lat_d = div_sel;
                    cyc_lat_d = cyc_sel;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                grant_d        = '0;
                grant_d[idx_q] = 1'b1;
                div_in_d       = div_lat_q;
                rst_n_d        = 1'b0;
                edge_cnt_d     = '0;
                divf_d         = 1'b0;
                if (abort) begin
                    state_d = S_GAP;
                end else if (cyc_lat_q == '0) begin
                    done_d[idx_q] = 1'b1;
                    state_d       = S_GAP;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rst_n_d = 1'b1;
                if (abort) begin
                    rst_n_d = 1'b0;
                    state_d = S_GAP;
                end else if (rise) begin
                    // Terminal edge: the divider goes back into reset together with the done pulse.
                    if (edge_cnt_q + CW'(1) == cyc_lat_q) begin
                        done_d[idx_q] = 1'b1;
                        rst_n_d       = 1'b0;
                        state_d       = S_GAP;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                grant_d = '0;
                rst_n_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= IW'(NREQ - 1);
            div_lat_q  <= '0;
            cyc_lat_q  <= '0;
            edge_cnt_q <= '0;
            divf_q     <= 1'b0;
            div_in_q   <= '0;
            rst_n_q    <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            div_lat_q  <= div_lat_d;
            cyc_lat_q  <= cyc_lat_d;
            edge_cnt_q <= edge_cnt_d;
            divf_q     <= divf_d;
            div_in_q   <= div_in_d;
            rst_n_q    <= rst_n_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
        end
    end

    assign div_in    = div_in_q;
    assign div_rst_n = rst_n_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule
